uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The module SHALL expose parameter NUM_REQ, default 4, the number of byte requesters sharing one uart_tx.
REQ-002 The module SHALL expose parameter BSY_TIMEOUT, default 4, the maximum cycles from send_trig to tx_bsy rising.
REQ-003 The module SHALL have one clock; reset is asynchronous and active-low.
REQ-004 Port: clk  in  1  system clock, all logic on rising edge.
REQ-005 Port: rst_n  in  1  asynchronous active-low reset.
REQ-006 Port: req  in  NUM_REQ  per-requester request, held high until its gnt.
REQ-007 Port: req_data  in  8*NUM_REQ  byte of requester i at bits [8i+7:8i].
REQ-008 Port: gnt  out  NUM_REQ  one-cycle pulse, byte of requester i accepted.
REQ-009 Port: done  out  NUM_REQ  one-cycle pulse, byte of requester i fully transmitted.
REQ-010 Port: send_trig  out  1  frame start pulse to uart_tx.
REQ-011 Port: send_data  out  8  byte to uart_tx.
REQ-012 Port: tx_bsy  in  1  uart_tx busy.
REQ-013 Port: busy  out  1  high in any state other than IDLE.
REQ-014 Port: err_timeout  out  1  sticky, tx_bsy failed to rise.
REQ-015 Port: clr_err  in  1  clears err_timeout.

Function
REQ-016 The FSM SHALL have states IDLE, TRIG, WAIT_START and WAIT_END.
REQ-017 IDLE: if |req and ~tx_bsy, select the winner by round-robin, searching from last_owner+1 upward and wrapping at NUM_REQ.
REQ-018 On that IDLE edge: capture req_data of the winner into send_data, record owner, set gnt[owner] for the next cycle only, go to TRIG.
REQ-019 TRIG: send_trig = 1 for exactly one cycle; clear the timeout counter; go to WAIT_START.
REQ-020 WAIT_START: tx_bsy = 1 -> WAIT_END.
REQ-021 WAIT_START: if BSY_TIMEOUT cycles elapse without tx_bsy, set err_timeout, skip done, leave last_owner unchanged, go to IDLE.
REQ-022 WAIT_END: tx_bsy = 0 -> pulse done[owner] for one cycle, set last_owner = owner, go to IDLE.
REQ-023 send_data SHALL hold stable from capture until the next capture, because uart_tx re-samples it every cycle during the frame.
REQ-024 send_data SHALL never change while tx_bsy = 1.
REQ-025 Latency: gnt SHALL appear 1 cycle after the accepting edge and send_trig 1 cycle after that.
REQ-026 Back-to-back: the next accept SHALL occur no earlier than the first IDLE cycle after tx_bsy falls.
REQ-027 Fairness: with all req high continuously, grants SHALL follow the order 0,1,...,NUM_REQ-1,0.
REQ-028 A requester SHALL NOT be granted twice while another requester is pending.
REQ-029 If req drops before gnt, no byte from that requester SHALL be sent.
REQ-030 req is ignored outside IDLE, so a req still high during its gnt cycle SHALL NOT cause a double accept.
REQ-031 If tx_bsy is already high in IDLE (foreign use), the arbiter SHALL wait.
REQ-032 If clr_err and a timeout occur in the same cycle, set SHALL win.
REQ-033 gnt, done and send_trig SHALL each be one-hot or zero.

Reset
REQ-034 rst_n low SHALL immediately force IDLE.
REQ-035 rst_n low SHALL force send_trig = 0, send_data = 0x00, gnt = 0, done = 0, busy = 0, err_timeout = 0 and timeout counter = 0.
REQ-036 rst_n low SHALL force last_owner = NUM_REQ-1, so requester 0 has first priority.
REQ-037 Reset mid-frame SHALL abandon the frame with no done pulse; release is synchronous to clk.

Structure
REQ-038 The shared package SHALL hold the FSM state encoding (2 bits), default NUM_REQ/BSY_TIMEOUT constants and the byte width of 8.
REQ-039 The round-robin pick SHALL be one combinational sub-module, rr_pick (inputs req, last_owner; outputs valid, index).

Verification
REQ-040 Single request: req = 0001, data 0xA5, uart_tx model holding tx_bsy for 91 cycles -> gnt = 0001 one cycle, send_trig one cycle later, send_data = 0xA5 throughout, done = 0001 after tx_bsy falls.
REQ-041 All requesting: req = 1111, data 0x10/0x21/0x32/0x43 -> transmitted 0x10, 0x21, 0x32, 0x43 in order with exactly one gnt each.
REQ-042 Fairness after service: requester 2 re-asserts immediately after its done while 3 is pending -> 3 is served before 2.
REQ-043 Timeout: tx_bsy held 0 -> err_timeout set 4 cycles after send_trig, no done, back to IDLE; clr_err pulse -> err_timeout = 0.
REQ-044 Reset mid-frame: rst_n low during WAIT_END -> all outputs at reset values in the same cycle, no done; after release req = 0010 is served normally.
REQ-045 Foreign busy: tx_bsy = 1 while req = 0001 -> no gnt until tx_bsy = 0.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and defaults for the uart_tx byte arbiter.
// FSM encoding, requester defaults and byte width.
package uart_tx_arbiter_pkg;

    localparam int NUM_REQ_DEF     = 4;
    localparam int BSY_TIMEOUT_DEF = 4;
    localparam int BYTE_W          = 8;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        TRIG       = 2'd1,
        WAIT_START = 2'd2,
        WAIT_END   = 2'd3
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin winner search, starting one past the last owner.
// Purely combinational.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    output logic               valid,
    output logic [IDX_W-1:0]   index
);

    int cand;

    // Walk from farthest to nearest so the nearest requester overwrites.
    always_comb begin
        valid = 1'b0;
        index = '0;
        cand  = 0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = (int'(last_owner) + i) % NUM_REQ;
            if (req[cand]) begin
                valid = 1'b1;
                index = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NUM_REQ byte requesters, round-robin,
// with a watchdog on tx_bsy rising after each frame trigger.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = NUM_REQ_DEF,
    parameter int BSY_TIMEOUT = BSY_TIMEOUT_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [BYTE_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic                      send_trig,
    output logic [BYTE_W-1:0]         send_data,
    input  logic                      tx_bsy,
    output logic                      busy,
    output logic                      err_timeout,
    input  logic                      clr_err
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(BSY_TIMEOUT + 1);

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [BYTE_W-1:0]   data_q, data_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic                trig_q, trig_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                pick_valid;
    logic [IDX_W-1:0]    pick_idx;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req        (req),
        .last_owner (last_q),
        .valid      (pick_valid),
        .index      (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        data_d  = data_q;
        gnt_d   = '0;
        done_d  = '0;
        trig_d  = 1'b0;
        cnt_d   = cnt_q;
        // A timeout set below overrides the clear.
        err_d   = err_q & ~clr_err;
        unique case (state_q)
            IDLE: begin
                if (pick_valid && !tx_bsy) begin
                    data_d          = req_data[pick_idx*BYTE_W +: BYTE_W];
                    owner_d         = pick_idx;
                    gnt_d[pick_idx] = 1'b1;
                    state_d         = TRIG;
                end
            end
            TRIG: begin
                trig_d  = 1'b1;
                cnt_d   = '0;
                state_d = WAIT_START;
            end
            WAIT_START: begin
                if (tx_bsy) begin
                    state_d = WAIT_END;
                end else if (cnt_q == CNT_W'(BSY_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_END: begin
                if (!tx_bsy) begin
                    done_d[owner_q] = 1'b1;
                    last_d          = owner_q;
                    state_d         = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            data_q  <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            trig_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            data_q  <= data_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            trig_q  <= trig_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt         = gnt_q;
    assign done        = done_q;
    assign send_trig   = trig_q;
    assign send_data   = data_q;
    assign busy        = (state_q != IDLE);
    assign err_timeout = err_q;

endmodule
